mmio_bridge: RTL
================

// Module: mmio_bridge
// PURPOSE
//  Sits directly downstream of the cpu byte bus (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full).
//  Decodes every access to 128KB RAM or to the I/O window (a[17:16]==2'b11).
//  Owns the UART TX buffer, the RX pop, the cycle counter and the program-stop flag.
//  Returns read data with fixed 1-cycle latency.
// PARAMETERS
//  TX_DEPTH     8   TX FIFO entries (power of 2, >=4)
//  FULL_MARGIN  2   free entries kept when io_buffer_full asserts (covers in-flight cpu writes)
// PORTS
//  clk_in        in   1   single clock
//  rst_in        in   1   asynchronous reset, active-low
//  rdy_in        in   1   cpu-side accesses have no side effects while low
//  cpu_a         in   32  byte address from cpu (mem_a)
//  cpu_wr        in   1   1=write, 0=read (mem_wr)
//  cpu_wdata     in   8   write byte (mem_dout)
//  cpu_rdata     out  8   read byte to cpu (mem_din), valid the cycle after the request
//  io_buffer_full out 1   TX FIFO near-full back-pressure to cpu
//  ram_en        out  1   RAM access strobe (combinational)
//  ram_wr        out  1   RAM write enable (combinational)
//  ram_a         out  17  RAM byte address = cpu_a[16:0]
//  ram_wdata     out  8   = cpu_wdata
//  ram_rdata     in   8   RAM read byte, registered inside the RAM (1-cycle)
//  rx_valid      in   1   UART RX byte available
//  rx_data       in   8   UART RX byte
//  rx_pop        out  1   1-cycle pulse consuming rx_data
//  tx_valid      out  1   TX FIFO non-empty
//  tx_data       out  8   TX FIFO head
//  tx_ready      in   1   UART accepts tx_data when tx_valid&tx_ready
//  program_stop  out  1   level; set after stop write once TX FIFO has drained
// BEHAVIOUR
//  Reset (rst_in low, async): all outputs 0; FIFO empty; counter 0; sel_q=RAM; stop_pending=0.
//  Decode: io = cpu_a[17:16]==2'b11; else RAM. ram_en = rdy_in & ~io. ram_wr = ram_en & cpu_wr.
//  Read path: register sel_q (RAM / IO) and io_rdata_q on every rdy_in-high read.
//   Next cycle: cpu_rdata = sel_q==RAM ? ram_rdata : io_rdata_q. Hold values while rdy_in low.
//  0x30000 read: rx_valid ? (io_rdata_q<=rx_data, rx_pop=1) : io_rdata_q<=8'h00, no pop.
//  0x30000 write: byte!=0 pushes to TX FIFO; byte==0 ignored. Push when FIFO full is dropped.
//   Dropping only happens when the cpu ignores io_buffer_full.
//  0x30004..0x30007 read: byte k of cnt_snap. A read of 0x30004 snapshots the live counter.
//   The return is byte 0 of that same value. This keeps the 4-byte dword consistent.
//  0x30004 write: push 8'h00 to TX FIFO; set stop_pending. program_stop<=1 when stop_pending & FIFO empty.
//   program_stop is sticky until reset.
//  Other IO addresses: reads return 0, writes have no effect.
//  Cycle counter: 32-bit, +1 every clk_in after reset regardless of rdy_in; wraps 0xFFFFFFFF->0.
//  TX FIFO: pop on tx_valid&tx_ready, independent of rdy_in.
//   Simultaneous push+pop: count unchanged, both occur, including when the FIFO is full.
//   Pointers wrap modulo TX_DEPTH.
//  io_buffer_full = count >= TX_DEPTH-FULL_MARGIN; registered and updated each cycle.
// STRUCTURE
//  Shared package: IO_BASE=32'h30000, IO_UART=2'b00 (a[2:0]==0), IO_CLK=3'b100.
//   Also RAM_AW=17 and the sel enum {SEL_RAM, SEL_IO}.
//  One sub-module: sync_fifo (W=8, DEPTH=TX_DEPTH, outputs count/full/empty, async active-low reset).
//  Counter, decode, read mux and stop logic stay in mmio_bridge.
// TESTING
//  RAM read a=0x00010, ram_rdata=0xA5 the next cycle -> cpu_rdata=0xA5 at t+1, ram_en=1, rx_pop=0.
//  Writes 'H','i',0x00 to 0x30000 with tx_ready=0 -> FIFO count 2, tx_data='H'.
//   Same test: io_buffer_full low until count 6 with defaults.
//  Counter=0x12345678 at the 0x30004 read -> bytes 0x78,0x56,0x34,0x12.
//   Counter still advances during the reads 0x30005..7.
//  Write 0x30004 with 3 bytes queued, tx_ready=1 -> 0x00 is the 4th TX byte.
//   Same test: program_stop rises the cycle after the FIFO empties.
//  rdy_in=0 during a 0x30000 read with rx_valid=1 -> no rx_pop, cpu_rdata unchanged.
//   rst_in low mid-transfer -> tx_valid=0 and program_stop=0 immediately.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// Shared constants and types for the cpu MMIO bridge: address map, RAM width, read-source select.
package mmio_bridge_pkg;

   localparam logic [31:0] IO_BASE = 32'h0003_0000;
   localparam logic [1:0]  IO_UART = 2'b00;
   localparam logic [2:0]  IO_CLK  = 3'b100;
   localparam int          RAM_AW  = 17;

   typedef enum logic {
      SEL_RAM = 1'b0,
      SEL_IO  = 1'b1
   } sel_e;

   // Byte k of a 32-bit dword, little-endian.
   function automatic logic [7:0] cnt_byte(input logic [31:0] v, input logic [1:0] k);
      return v[{k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mmio_bridge_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       push_i,
   input  logic [W-1:0]               wdata_i,
   input  logic                       pop_i,
   output logic [W-1:0]               rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [$clog2(DEPTH):0]     count_nxt_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [AW:0]             count_q, count_d;
   logic                    do_push, do_pop;

   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == (AW+1)'(DEPTH));
   assign do_pop      = pop_i & ~empty_o;
   assign do_push     = push_i & (~full_o | do_pop);
   assign rdata_o     = mem_q[rd_ptr_q];
   assign count_o     = count_q;
   assign count_nxt_o = count_d;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: empty_o masks stale entries.
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/mmio_bridge.sv
// CPU byte-bus decoder: RAM vs I/O window, UART TX FIFO / RX pop, cycle counter, program stop.
module mmio_bridge
   import mmio_bridge_pkg::*;
#(
   parameter int TX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [31:0]       cpu_a,
   input  logic              cpu_wr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              io_buffer_full,
   output logic              ram_en,
   output logic              ram_wr,
   output logic [RAM_AW-1:0] ram_a,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_pop,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              program_stop
);
   localparam int CW = $clog2(TX_DEPTH) + 1;

   logic          io, rd_req, wr_req, uart_hit, clk_hit, clk0_hit;
   logic          push_en, stop_set, tx_pop, fifo_empty;
   logic [7:0]    push_data, io_rdata_d, io_rdata_q;
   logic [31:0]   cnt_q, cnt_snap_q;
   logic [CW-1:0] fifo_count, fifo_count_nxt;
   logic          stop_pending_q, program_stop_q, full_q;
   sel_e          sel_q;
   logic          unused_hi;

   assign unused_hi = ^cpu_a[31:18];

   assign io       = (cpu_a[17:16] == IO_BASE[17:16]);
   assign rd_req   = rdy_in & ~cpu_wr;
   assign wr_req   = rdy_in & cpu_wr;
   assign uart_hit = (cpu_a[15:3] == '0) && (cpu_a[2:0] == {1'b0, IO_UART});
   assign clk_hit  = (cpu_a[15:3] == '0) && (cpu_a[2] == IO_CLK[2]);
   assign clk0_hit = clk_hit && (cpu_a[1:0] == IO_CLK[1:0]);

   assign ram_en    = rdy_in & ~io;
   assign ram_wr    = ram_en & cpu_wr;
   assign ram_a     = cpu_a[RAM_AW-1:0];
   assign ram_wdata = cpu_wdata;
   assign rx_pop    = rd_req & io & uart_hit & rx_valid;

   // A zero byte to the UART is a no-op; the stop write queues a 0x00 marker instead.
   always_comb begin
      push_en   = 1'b0;
      push_data = 8'h00;
      stop_set  = 1'b0;
      if (wr_req && io) begin
         if (uart_hit && cpu_wdata != 8'h00) begin
            push_en   = 1'b1;
            push_data = cpu_wdata;
         end else if (clk0_hit) begin
            push_en  = 1'b1;
            stop_set = 1'b1;
         end
      end
   end

   // Offset 4 returns the live counter low byte while the snapshot captures the whole dword.
   always_comb begin
      io_rdata_d = 8'h00;
      if (io) begin
         if (uart_hit)
            io_rdata_d = rx_valid ? rx_data : 8'h00;
         else if (clk0_hit)
            io_rdata_d = cnt_q[7:0];
         else if (clk_hit)
            io_rdata_d = cnt_byte(cnt_snap_q, cpu_a[1:0]);
      end
   end

   assign tx_pop = tx_valid & tx_ready;

   sync_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .push_i      (push_en),
      .wdata_i     (push_data),
      .pop_i       (tx_pop),
      .rdata_o     (tx_data),
      .count_o     (fifo_count),
      .count_nxt_o (fifo_count_nxt),
      .full_o      (),
      .empty_o     (fifo_empty)
   );

   assign tx_valid       = ~fifo_empty;
   assign io_buffer_full = full_q;
   assign program_stop   = program_stop_q;
   assign cpu_rdata      = (sel_q == SEL_RAM) ? ram_rdata : io_rdata_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q          <= '0;
         cnt_snap_q     <= '0;
         sel_q          <= SEL_RAM;
         io_rdata_q     <= '0;
         stop_pending_q <= 1'b0;
         program_stop_q <= 1'b0;
         full_q         <= 1'b0;
      end else begin
         cnt_q <= cnt_q + 32'd1;
         if (rd_req) begin
            sel_q      <= io ? SEL_IO : SEL_RAM;
            io_rdata_q <= io_rdata_d;
            if (io && clk0_hit) cnt_snap_q <= cnt_q;
         end
         if (stop_set) stop_pending_q <= 1'b1;
         if (stop_pending_q && fifo_empty) program_stop_q <= 1'b1;
         // Registered from next count so the flag tracks the FIFO count in the same cycle.
         full_q <= (fifo_count_nxt >= CW'(TX_DEPTH - FULL_MARGIN));
      end
   end

endmodule
